// File: rtl/uart_led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_led_pkg
// Brief    : Opcodes, reply codes, register addresses and parser states
//            shared by the UART LED controller.
// Revision : 1.0 - initial release
// ============================================================================
package uart_led_pkg;

    localparam logic [7:0] OP_WR     = 8'h57;
    localparam logic [7:0] OP_RD     = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;
    localparam logic [7:0] ADDR_PAT0 = 8'h00;
    localparam logic [7:0] ADDR_MODE = 8'h10;
    localparam logic [7:0] ADDR_BDIV = 8'h11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Pattern bytes occupy 0..n_pat-1; MODE and BDIV sit at fixed addresses.
    function automatic logic addr_valid(input logic [7:0] a, input int n_pat);
        return (32'(a) < 32'(n_pat)) || (a == ADDR_MODE) || (a == ADDR_BDIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Brief    : Tick divider, free-running counter, blink phase and LED mux.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int N_LEDS      = 8,
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_LEDS-1:0] i_pat,
    input  logic [1:0]        i_mode,
    input  logic [7:0]        i_bdiv,
    input  logic              i_bdiv_wr,
    output logic [N_LEDS-1:0] o_leds
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [TW-1:0]     r_tick_cnt;
    logic [N_LEDS-1:0] r_count;
    logic [7:0]        r_blink_cnt;
    logic              r_phase;
    logic [N_LEDS-1:0] r_leds;
    logic              w_tick;
    logic [7:0]        w_bdiv_eff;
    logic [N_LEDS-1:0] w_base;
    logic [N_LEDS-1:0] w_gate;

    assign w_tick     = (r_tick_cnt == TW'(TICK_CYCLES - 1));
    assign w_bdiv_eff = (i_bdiv == 8'd0) ? 8'd1 : i_bdiv;
    assign w_base     = i_mode[0] ? r_count : i_pat;
    assign w_gate     = i_mode[1] ? {N_LEDS{r_phase}} : {N_LEDS{1'b1}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt  <= '0;
            r_count     <= '0;
            r_blink_cnt <= 8'd0;
            r_phase     <= 1'b1;
            r_leds      <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            if (w_tick)
                r_count <= r_count + N_LEDS'(1);
            // A new divisor restarts the half-period but keeps the current phase.
            if (i_bdiv_wr) begin
                r_blink_cnt <= 8'd0;
            end else if (w_tick) begin
                if (r_blink_cnt >= w_bdiv_eff - 8'd1) begin
                    r_blink_cnt <= 8'd0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 8'd1;
                end
            end
            r_leds <= w_base & w_gate;
        end
    end

    assign o_leds = r_leds;

endmodule
`default_nettype wire

// File: rtl/uart_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_led_ctrl
// Brief    : UART command slave (3-byte write, 2-byte read) driving an LED
//            bank. Define UART_LED_TIMEOUT_EN for the inter-byte timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_led_ctrl
    import uart_led_pkg::*;
#(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int N_LEDS         = 8,
    parameter int TICK_CYCLES    = CLK_FREQ,
    parameter int TIMEOUT_CYCLES = CLK_FREQ / 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [N_LEDS-1:0] leds,
    output logic              cmd_err
);

    localparam int NB = N_LEDS / 8;

    if ((N_LEDS % 8) != 0 || N_LEDS < 8 || N_LEDS > 32 ||
        TICK_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_led_ctrl: illegal parameter value");
    end

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_op, r_addr, r_rsp;
    logic              r_cmd_err;
    logic [N_LEDS-1:0] r_pat;
    logic [1:0]        r_mode;
    logic [7:0]        r_bdiv;
    logic              w_accept, w_load_rsp, w_nak, w_wr_en, w_timeout;
    logic [7:0]        w_rsp_nxt, w_rd_data;

    assign s_axis_tready = (r_state != ST_RESP);
    assign w_accept      = s_axis_tvalid && s_axis_tready;

`ifdef UART_LED_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    logic [GW-1:0] r_gap;
    logic          w_in_cmd;

    assign w_in_cmd  = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_timeout = w_in_cmd && !w_accept && (r_gap == GW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_gap <= '0;
        else if (w_accept || !w_in_cmd)
            r_gap <= '0;
        else
            r_gap <= r_gap + GW'(1);
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Read data is looked up from the address byte while it is being accepted.
    always_comb begin
        w_rd_data = 8'h00;
        if (s_axis_tdata == ADDR_MODE) begin
            w_rd_data = {6'b0, r_mode};
        end else if (s_axis_tdata == ADDR_BDIV) begin
            w_rd_data = r_bdiv;
        end else begin
            for (int k = 0; k < NB; k++)
                if (s_axis_tdata == 8'(ADDR_PAT0 + k))
                    w_rd_data = r_pat[8*k +: 8];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_rsp  = 1'b0;
        w_rsp_nxt   = RSP_NAK;
        w_nak       = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) begin
                if (s_axis_tdata == OP_WR || s_axis_tdata == OP_RD) begin
                    w_state_nxt = ST_ADDR;
                end else begin
                    w_state_nxt = ST_RESP;
                    w_load_rsp  = 1'b1;
                    w_nak       = 1'b1;
                end
            end
            ST_ADDR: if (w_accept) begin
                if (r_op == OP_WR) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_RESP;
                    w_load_rsp  = 1'b1;
                    if (addr_valid(s_axis_tdata, NB))
                        w_rsp_nxt = w_rd_data;
                    else
                        w_nak = 1'b1;
                end
            end
            ST_DATA: if (w_accept) begin
                w_state_nxt = ST_RESP;
                w_load_rsp  = 1'b1;
                if (addr_valid(r_addr, NB)) begin
                    w_wr_en   = 1'b1;
                    w_rsp_nxt = RSP_ACK;
                end else begin
                    w_nak = 1'b1;
                end
            end
            ST_RESP: if (m_axis_tready)
                w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_timeout)
            w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= 8'h00;
            r_addr    <= 8'h00;
            r_rsp     <= 8'h00;
            r_cmd_err <= 1'b0;
            r_pat     <= '0;
            r_mode    <= 2'b00;
            r_bdiv    <= 8'h00;
        end else begin
            r_cmd_err <= w_nak;
            if (r_state == ST_IDLE && w_accept)
                r_op <= s_axis_tdata;
            if (r_state == ST_ADDR && w_accept)
                r_addr <= s_axis_tdata;
            if (w_load_rsp)
                r_rsp <= w_rsp_nxt;
            if (w_wr_en) begin
                case (r_addr)
                    ADDR_MODE: r_mode <= s_axis_tdata[1:0];
                    ADDR_BDIV: r_bdiv <= s_axis_tdata;
                    default: begin
                        for (int k = 0; k < NB; k++)
                            if (r_addr == 8'(ADDR_PAT0 + k))
                                r_pat[8*k +: 8] <= s_axis_tdata;
                    end
                endcase
            end
        end
    end

    led_pattern_gen #(
        .N_LEDS      (N_LEDS),
        .TICK_CYCLES (TICK_CYCLES)
    ) u_led_pattern_gen (
        .clk       (clk),
        .rst       (rst),
        .i_pat     (r_pat),
        .i_mode    (r_mode),
        .i_bdiv    (r_bdiv),
        .i_bdiv_wr (w_wr_en && (r_addr == ADDR_BDIV)),
        .o_leds    (leds)
    );

    assign m_axis_tvalid = (r_state == ST_RESP);
    assign m_axis_tdata  = r_rsp;
    assign cmd_err       = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_led_ctrl
// Brief    : Directed, table-driven checks of the UART LED controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_led_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic [7:0] leds;
    logic       cmd_err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    logic [7:0] rsp_q[$];

    uart_led_ctrl #(
        .CLK_FREQ       (1000),
        .N_LEDS         (8),
        .TICK_CYCLES    (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .leds          (leds),
        .cmd_err       (cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_err)
            err_cnt++;
        if (m_axis_tvalid && m_axis_tready)
            rsp_q.push_back(m_axis_tdata);
    end

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         n;
        logic [7:0] rsp;
        int         err;
        bit         chk_led;
        logic [7:0] led;
    } vec_t;

    vec_t vt[15];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200)
            check_eq("s_tready_timeout", 32'(s_axis_tready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        err_cnt = 0;
        rsp_q.delete();
        send_byte(v.b0);
        if (v.n > 1) send_byte(v.b1);
        if (v.n > 2) send_byte(v.b2);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        check_eq("rsp_latency_valid", 32'(m_axis_tvalid), 32'd1);
        check_eq("rsp_data", 32'(m_axis_tdata), 32'(v.rsp));
        @(negedge clk);
        check_eq("rsp_valid_drop", 32'(m_axis_tvalid), 32'd0);
        check_eq("rsp_count", 32'(rsp_q.size()), 32'd1);
        check_eq("cmd_err_pulses", 32'(err_cnt), 32'(v.err));
        if (v.chk_led)
            check_eq("leds_after_write", 32'(leds), 32'(v.led));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{8'h57, 8'h00, 8'hA5, 3, 8'h06, 0, 1'b1, 8'hA5};
        vt[1]  = '{8'h52, 8'h00, 8'h00, 2, 8'hA5, 0, 1'b0, 8'h00};
        vt[2]  = '{8'h52, 8'h20, 8'h00, 2, 8'h15, 1, 1'b0, 8'h00};
        vt[3]  = '{8'h00, 8'h00, 8'h00, 1, 8'h15, 1, 1'b0, 8'h00};
        vt[4]  = '{8'h57, 8'h10, 8'h07, 3, 8'h06, 0, 1'b0, 8'h00};
        vt[5]  = '{8'h52, 8'h10, 8'h00, 2, 8'h03, 0, 1'b0, 8'h00};
        vt[6]  = '{8'h57, 8'h11, 8'h05, 3, 8'h06, 0, 1'b0, 8'h00};
        vt[7]  = '{8'h52, 8'h11, 8'h00, 2, 8'h05, 0, 1'b0, 8'h00};
        vt[8]  = '{8'h57, 8'h20, 8'h11, 3, 8'h15, 1, 1'b0, 8'h00};
        vt[9]  = '{8'h52, 8'h01, 8'h00, 2, 8'h15, 1, 1'b0, 8'h00};
        vt[10] = '{8'h57, 8'h01, 8'h33, 3, 8'h15, 1, 1'b0, 8'h00};
        vt[11] = '{8'h57, 8'h10, 8'h00, 3, 8'h06, 0, 1'b1, 8'hA5};
        vt[12] = '{8'h52, 8'h00, 8'h00, 2, 8'hA5, 0, 1'b0, 8'h00};
        vt[13] = '{8'h57, 8'h11, 8'h00, 3, 8'h06, 0, 1'b0, 8'h00};
        vt[14] = '{8'h52, 8'h11, 8'h00, 2, 8'h00, 0, 1'b0, 8'h00};

        repeat (3) @(negedge clk);
        check_eq("reset_leds", 32'(leds), 32'd0);
        check_eq("reset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("reset_m_tdata", 32'(m_axis_tdata), 32'd0);
        check_eq("reset_cmd_err", 32'(cmd_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_s_tready", 32'(s_axis_tready), 32'd1);

        for (int i = 0; i < 15; i++)
            run_vec(vt[i]);

        // Unknown opcode with the transmitter stalled for 50 cycles.
        begin
            int bad = 0;
            m_axis_tready = 1'b0;
            err_cnt = 0;
            rsp_q.delete();
            send_byte(8'h41);
            @(negedge clk);
            s_axis_tvalid = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h15 || s_axis_tready !== 1'b0)
                    bad++;
                @(negedge clk);
            end
            check_eq("stall_stable_cycles_bad", 32'(bad), 32'd0);
            m_axis_tready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check_eq("stall_valid_drop", 32'(m_axis_tvalid), 32'd0);
            check_eq("stall_rsp_count", 32'(rsp_q.size()), 32'd1);
            check_eq("stall_cmd_err_pulses", 32'(err_cnt), 32'd1);
        end

        // Counter mode: +1 every 4 cycles, including the 0xFF -> 0x00 wrap.
        run_vec('{8'h57, 8'h10, 8'h01, 3, 8'h06, 0, 1'b0, 8'h00});
        begin
            int last_chg = -1;
            bit wrapped = 1'b0;
            logic [7:0] prev;
            prev = leds;
            for (int i = 0; i < 1100; i++) begin
                @(negedge clk);
                if (leds !== prev) begin
                    if (last_chg >= 0) begin
                        check_eq("cnt_step", 32'(leds), 32'(8'(prev + 8'd1)));
                        check_eq("cnt_period", 32'(i - last_chg), 32'd4);
                    end
                    if (prev == 8'hFF && leds == 8'h00)
                        wrapped = 1'b1;
                    last_chg = i;
                    prev = leds;
                end
            end
            check_eq("cnt_wrap_seen", 32'(wrapped), 32'd1);
        end

        // Blink over the static pattern, BDIV=2 -> 8-cycle half period.
        run_vec('{8'h57, 8'h11, 8'h02, 3, 8'h06, 0, 1'b0, 8'h00});
        run_vec('{8'h57, 8'h10, 8'h02, 3, 8'h06, 0, 1'b0, 8'h00});
        begin
            int last_chg = -1;
            int bad_val = 0;
            int n_chg = 0;
            logic [7:0] prev;
            prev = leds;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                if (leds !== 8'h00 && leds !== 8'hA5)
                    bad_val++;
                if (leds !== prev) begin
                    if (last_chg >= 0)
                        check_eq("blink_period", 32'(i - last_chg), 32'd8);
                    n_chg++;
                    last_chg = i;
                    prev = leds;
                end
            end
            check_eq("blink_bad_values", 32'(bad_val), 32'd0);
            check_eq("blink_toggles_80cyc", 32'(n_chg >= 9), 32'd1);
        end

        // Stalled write: timeout discards it, otherwise it completes late.
        run_vec('{8'h57, 8'h10, 8'h00, 3, 8'h06, 0, 1'b0, 8'h00});
        run_vec('{8'h57, 8'h00, 8'h00, 3, 8'h06, 0, 1'b1, 8'h00});
        err_cnt = 0;
        rsp_q.delete();
        send_byte(8'h57);
        send_byte(8'h00);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        repeat (100) @(negedge clk);
        send_byte(8'h52);
        send_byte(8'h00);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        repeat (10) @(negedge clk);
`ifdef UART_LED_TIMEOUT_EN
        check_eq("to_rsp_count", 32'(rsp_q.size()), 32'd1);
        check_eq("to_rsp0", 32'((rsp_q.size() > 0) ? rsp_q[0] : 8'hEE), 32'h00);
        check_eq("to_cmd_err", 32'(err_cnt), 32'd0);
        check_eq("to_leds", 32'(leds), 32'h00);
`else
        check_eq("stall_rsp_count2", 32'(rsp_q.size()), 32'd2);
        check_eq("stall_rsp0", 32'((rsp_q.size() > 0) ? rsp_q[0] : 8'hEE), 32'h06);
        check_eq("stall_rsp1", 32'((rsp_q.size() > 1) ? rsp_q[1] : 8'hEE), 32'h15);
        check_eq("stall_cmd_err", 32'(err_cnt), 32'd1);
        check_eq("stall_leds", 32'(leds), 32'h52);
`endif

        // Asynchronous reset while a reply is held.
        run_vec('{8'h57, 8'h00, 8'hC3, 3, 8'h06, 0, 1'b1, 8'hC3});
        m_axis_tready = 1'b0;
        send_byte(8'h41);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_valid", 32'(m_axis_tvalid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("rst_leds", 32'(leds), 32'd0);
        check_eq("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_axis_tready = 1'b1;
        run_vec('{8'h57, 8'h00, 8'h3C, 3, 8'h06, 0, 1'b1, 8'h3C});
        run_vec('{8'h52, 8'h10, 8'h00, 2, 8'h00, 0, 1'b0, 8'h00});
        run_vec('{8'h52, 8'h00, 8'h00, 2, 8'h3C, 0, 1'b0, 8'h00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_led_ctrl.md
Name: uart_led_ctrl

Overview:
- UART command slave driving a parametrised LED bank; successor to the fixed 8-LED counter and UART loopback top.
- Sits between uart_rx (AXI-stream slave side) and uart_tx (AXI-stream master side).
- Parses 3-byte write and 2-byte read commands into an 8-bit register file.
- Registers select static pattern, free-running counter or blink mode for the LEDs.

Parameters:
- CLK_FREQ, 100_000_000, clock frequency in Hz.
- N_LEDS, 8, LED count; multiple of 8, range 8..32.
- TICK_CYCLES, CLK_FREQ, cycles per counter-mode increment and per blink half-period unit.
- TIMEOUT_CYCLES, CLK_FREQ/10, maximum inter-byte gap inside a command (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- s_axis_tdata  in  8  received byte
- s_axis_tvalid  in  1  received byte valid
- s_axis_tready  out  1  ready to accept a byte
- m_axis_tdata  out  8  reply byte
- m_axis_tvalid  out  1  reply valid
- m_axis_tready  in  1  transmitter ready
- leds  out  N_LEDS  LED drive
- cmd_err  out  1  one-cycle pulse on a NAK'd command

Behaviour:
- Reset values: all outputs 0; all registers 0; parser in IDLE.
- A byte transfers when tvalid && tready. The master holds m_axis_tdata stable while m_axis_tvalid=1 until m_axis_tready=1.
- Register map:
  - 0x00..N_LEDS/8-1: PAT[k], LED bits 8k+7..8k.
  - 0x10: MODE. bit0 = counter mode, bit1 = blink enable; other bits read 0.
  - 0x11: BDIV, blink half-period in ticks; value 0 is treated as 1.
  - Any other address is invalid.
- Opcodes: 0x57 'W' (write), 0x52 'R' (read). Replies: 0x06 ACK, 0x15 NAK.
- FSM states: IDLE, ADDR, DATA, RESP.
  - s_axis_tready=1 in IDLE, ADDR and DATA; 0 in RESP.
  - IDLE: 'W' or 'R' latches the opcode -> ADDR. Any other byte -> RESP with NAK.
  - ADDR: latch address.
    - 'W' -> DATA.
    - 'R' with a valid address -> RESP with the register value.
    - 'R' with an invalid address -> RESP with NAK.
  - DATA: valid address -> write the register in the acceptance cycle, RESP with ACK. Invalid address -> no write, RESP with NAK.
  - RESP: m_axis_tvalid=1. On the handshake -> IDLE, m_axis_tvalid=0 on the next cycle.
- Minimum latency from the last command byte accepted to m_axis_tvalid high is 1 cycle.
- cmd_err pulses for one cycle in the cycle the parser enters RESP with NAK.
- LED output (registered, 1 cycle after the register write):
  - base = counter value if MODE.bit0, else {PAT}.
  - The counter is N_LEDS wide, increments once per TICK_CYCLES and wraps from all-ones to 0. It runs continuously regardless of mode.
  - If MODE.bit1, leds = base AND blink_phase. blink_phase toggles every BDIV ticks and resets to 1.
  - Writing BDIV restarts the blink tick count with the phase unchanged.
- Reset asserted mid-command or mid-reply aborts immediately: state IDLE, m_axis_tvalid=0, registers cleared.

Optional Feature:
- Macro: UART_LED_TIMEOUT_EN.
- Defined:
  - A gap counter runs in ADDR and DATA and is cleared on each accepted byte.
  - Reaching TIMEOUT_CYCLES returns the FSM to IDLE silently: no reply, no write, no cmd_err.
- Undefined: no counter; the parser waits indefinitely for the remaining bytes.

Decomposition:
- Package uart_led_pkg holds:
  - opcode constants OP_WR, OP_RD;
  - reply constants RSP_ACK, RSP_NAK;
  - addresses ADDR_PAT0, ADDR_MODE, ADDR_BDIV;
  - the FSM state enum.
- Sub-module led_pattern_gen: tick divider, free-running counter, blink phase and output mux. Inputs are the register values; output is leds.

Test Plan:
- Bytes 0x57,0x00,0xA5 with m_axis_tready=1 -> reply 0x06, leds=0xA5 one cycle after the data byte, cmd_err=0.
- Bytes 0x52,0x00 after the above -> reply 0xA5. Then 0x52,0x20 -> reply 0x15, cmd_err pulses exactly one cycle.
- Byte 0x41 in IDLE -> reply 0x15. Hold m_axis_tready=0 for 50 cycles -> m_axis_tvalid and tdata stable, s_axis_tready=0 throughout.
- Run with TICK_CYCLES=4, write MODE=0x01 -> leds counts 0,1,2 at 4-cycle steps and wraps 0xFF->0x00. Then write MODE=0x03, BDIV=2 -> output gated off and on every 8 cycles.
- With UART_LED_TIMEOUT_EN and TIMEOUT_CYCLES=100, send 0x57,0x00, then idle 100 cycles, then 0x52,0x00 -> exactly one reply 0x00, pattern unchanged. Repeat without the macro -> the stalled command completes when the third byte arrives.
- Assert rst while in RESP with m_axis_tready=0 -> m_axis_tvalid=0 and leds=0 immediately. After release, the first command is parsed correctly.
